// File: rtl/adc_lane_align_ctrl.sv
// Training and alignment sequencer for one ADC channel's two 6-bit SERDES lanes.
// For each lane it resets the I/O, sweeps IDELAY taps to find the widest stable
// eye, loads the eye-centre tap, then bitslips until the lane word matches the
// training pattern.
module adc_lane_align_ctrl #(
  parameter logic [11:0] TRAIN_PATTERN = 12'hA5C,
  parameter int          SETTLE_CYCLES = 16,
  parameter int          CHECK_SAMPLES = 64,
  parameter int          MIN_EYE       = 4
) (
  input  logic        lclk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] adc_bits,
  input  logic [4:0]  delay_tap_out_0,
  input  logic [4:0]  delay_tap_out_1,
  output logic [1:0]  in_delay_reset,
  output logic [4:0]  delay_tap_in_0,
  output logic [4:0]  delay_tap_in_1,
  output logic [1:0]  adc_bitslip,
  output logic [1:0]  adc_io_reset,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic        fail_lane,
  output logic [4:0]  tap_result_0,
  output logic [4:0]  tap_result_1,
  output logic [2:0]  slip_count_0,
  output logic [2:0]  slip_count_1
);

  typedef enum logic [3:0] {
    S_IDLE, S_IORST, S_WAIT, S_LOAD, S_VERIFY, S_SAMPLE, S_EVAL,
    S_SLIPCHK, S_SLIP, S_LANE_DONE, S_DONE, S_FAIL
  } state_t;

  localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES - 1);
  localparam logic [9:0] CHECK_LAST  = 10'(CHECK_SAMPLES - 1);
  localparam logic [9:0] IORST_LAST  = 10'd3;
  localparam logic [5:0] MIN_EYE_W   = 6'(MIN_EYE);

  state_t      state, next_state, ret;
  logic [9:0]  cnt;
  logic        lane, centre;
  logic [4:0]  tap, cur_start, best_start;
  logic [5:0]  cur_len, best_len, ref_word;
  logic [2:0]  slip_cnt;
  logic [5:0]  word, pat_word, run_len;
  logic [4:0]  tap_now, run_start, centre_tap;
  logic        samp_mis, samp_end, last_tap;

  assign word       = lane ? adc_bits[11:6] : adc_bits[5:0];
  assign pat_word   = lane ? TRAIN_PATTERN[11:6] : TRAIN_PATTERN[5:0];
  assign tap_now    = lane ? delay_tap_out_1 : delay_tap_out_0;
  assign last_tap   = (tap == 5'd31);
  // First sample is the reference; any later deviation fails the tap.
  assign samp_mis   = (cnt != 10'd0) && (word != ref_word);
  assign samp_end   = samp_mis || (cnt == CHECK_LAST);
  assign run_len    = cur_len + 6'd1;
  assign run_start  = (cur_len == 6'd0) ? tap : cur_start;
  // best_start + best_len/2 stays inside the run, so it never exceeds 31.
  assign centre_tap = best_start + best_len[5:1];

  assign delay_tap_in_0 = lane ? 5'd0 : tap;
  assign delay_tap_in_1 = lane ? tap : 5'd0;

  // State register.
  always_ff @(posedge lclk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode and per-lane strobes (only the active lane's bit).
  always_comb begin
    next_state     = state;
    in_delay_reset = 2'b00;
    adc_bitslip    = 2'b00;
    adc_io_reset   = 2'b00;
    case (state)
      S_IDLE:      if (start) next_state = S_IORST;
      S_IORST: begin
        adc_io_reset[lane] = 1'b1;
        if (cnt == IORST_LAST) next_state = S_WAIT;
      end
      S_WAIT:      if (cnt == SETTLE_LAST) next_state = ret;
      S_LOAD: begin
        in_delay_reset[lane] = 1'b1;
        next_state = S_WAIT;
      end
      S_VERIFY: begin
        if (tap_now != tap) next_state = S_FAIL;
        else if (centre)    next_state = S_SLIPCHK;
        else                next_state = S_SAMPLE;
      end
      S_SAMPLE:    if (samp_end) next_state = last_tap ? S_EVAL : S_LOAD;
      S_EVAL:      next_state = (best_len < MIN_EYE_W) ? S_FAIL : S_LOAD;
      S_SLIPCHK: begin
        if (word != pat_word)        next_state = (slip_cnt == 3'd5) ? S_FAIL : S_SLIP;
        else if (cnt == CHECK_LAST)  next_state = S_LANE_DONE;
      end
      S_SLIP: begin
        adc_bitslip[lane] = 1'b1;
        next_state = S_WAIT;
      end
      S_LANE_DONE: next_state = lane ? S_DONE : S_IORST;
      S_DONE:      next_state = S_IDLE;
      S_FAIL:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Sequencer datapath: timers, tap sweep, eye tracking, slips and results.
  always_ff @(posedge lclk or posedge rst) begin
    if (rst) begin
      cnt <= '0; ret <= S_IDLE; lane <= 1'b0; centre <= 1'b0; tap <= '0;
      cur_start <= '0; cur_len <= '0; best_start <= '0; best_len <= '0;
      ref_word <= '0; slip_cnt <= '0;
      busy <= 1'b0; done <= 1'b0; fail <= 1'b0; fail_lane <= 1'b0;
      tap_result_0 <= '0; tap_result_1 <= '0;
      slip_count_0 <= '0; slip_count_1 <= '0;
    end else begin
      cnt <= (next_state != state) ? 10'd0 : cnt + 10'd1;
      case (state)
        S_IDLE: if (start) begin
          busy <= 1'b1; done <= 1'b0; fail <= 1'b0; fail_lane <= 1'b0;
          tap_result_0 <= '0; tap_result_1 <= '0;
          slip_count_0 <= '0; slip_count_1 <= '0;
          lane <= 1'b0;
        end
        S_IORST: begin
          ret <= S_LOAD; tap <= '0; centre <= 1'b0; slip_cnt <= '0;
          cur_start <= '0; cur_len <= '0; best_start <= '0; best_len <= '0;
        end
        S_LOAD: ret <= S_VERIFY;
        S_SAMPLE: begin
          if (cnt == 10'd0) ref_word <= word;
          if (samp_end) begin
            if (samp_mis) cur_len <= '0;
            else begin
              cur_len   <= run_len;
              cur_start <= run_start;
              // Strictly greater: the first-found run wins on ties.
              if (run_len > best_len) begin
                best_len   <= run_len;
                best_start <= run_start;
              end
            end
            if (!last_tap) tap <= tap + 5'd1;
          end
        end
        S_EVAL: if (best_len >= MIN_EYE_W) begin
          tap    <= centre_tap;
          centre <= 1'b1;
          if (lane) tap_result_1 <= centre_tap;
          else      tap_result_0 <= centre_tap;
        end
        S_SLIP: begin
          ret      <= S_SLIPCHK;
          slip_cnt <= slip_cnt + 3'd1;
          if (lane) slip_count_1 <= slip_cnt + 3'd1;
          else      slip_count_0 <= slip_cnt + 3'd1;
        end
        S_LANE_DONE: if (!lane) lane <= 1'b1;
        S_DONE: begin
          done <= 1'b1; busy <= 1'b0;
        end
        S_FAIL: begin
          fail <= 1'b1; fail_lane <= lane; busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
